// File: rtl/capture_buffer.sv
// Pre/post-trigger capture buffer: records samples while armed, freezes a DEPTH-word window around an accepted trigger and drains it oldest-first.
// Optional build macro CAPTURE_DECIM_EN adds a div[3:0] input that decimates the sample stream (strobe every div+1 cycles).
module capture_buffer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16,
    parameter int PRE   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic [WIDTH-1:0] in_data,
    input  logic             trig,
`ifdef CAPTURE_DECIM_EN
    input  logic [3:0]       div,
`endif
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   PRE_W   = (AW+1)'(PRE);
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LAST_W  = (AW+1)'(DEPTH - 1);
    localparam logic [AW-1:0] POST_W  = AW'(DEPTH - PRE - 1);

    typedef enum logic [1:0] {IDLE, PRETRIG, POSTTRIG, DRAIN} state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    post_cnt;
    logic [AW:0]      fill;
    logic [AW:0]      rd_cnt;
    logic             arm_q;
    logic             strobe;
    logic             wr_en;

`ifdef CAPTURE_DECIM_EN
    logic [3:0] presc;

    assign strobe = (presc == div);

    // Prescaler restarts with every capture so the first strobe lands div cycles after arming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (state == PRETRIG || state == POSTTRIG) begin
            presc <= strobe ? 4'd0 : presc + 4'd1;
        end else begin
            presc <= '0;
        end
    end
`else
    assign strobe = 1'b1;
`endif

    assign wr_en    = arm && strobe && (state == PRETRIG || state == POSTTRIG);
    assign rd_valid = (state == DRAIN) && (rd_cnt < DEPTH_W);
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
    assign busy     = (state == PRETRIG) || (state == POSTTRIG);
    assign done     = (state == DRAIN);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            post_cnt <= '0;
            fill     <= '0;
            rd_cnt   <= '0;
            arm_q    <= 1'b0;
        end else begin
            arm_q <= arm;
            case (state)
                IDLE: begin
                    if (arm && !arm_q) begin
                        state  <= PRETRIG;
                        wr_ptr <= '0;
                        fill   <= '0;
                    end
                end
                PRETRIG: begin
                    if (!arm) begin
                        state <= IDLE;
                    end else if (strobe) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (fill < DEPTH_W) begin
                            fill <= fill + 1'b1;
                        end
                        // fill is the pre-write count, so the trigger sample itself is post sample #0.
                        if (trig && fill >= PRE_W) begin
                            post_cnt <= POST_W;
                            if (POST_W == '0) begin
                                state  <= DRAIN;
                                rd_ptr <= wr_ptr + 1'b1;
                                rd_cnt <= '0;
                            end else begin
                                state <= POSTTRIG;
                            end
                        end
                    end
                end
                POSTTRIG: begin
                    if (!arm) begin
                        state <= IDLE;
                    end else if (strobe) begin
                        wr_ptr   <= wr_ptr + 1'b1;
                        post_cnt <= post_cnt - 1'b1;
                        if (post_cnt == AW'(1)) begin
                            state  <= DRAIN;
                            rd_ptr <= wr_ptr + 1'b1;
                            rd_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (rd_valid && rd_ready) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        rd_cnt <= rd_cnt + 1'b1;
                        if (rd_cnt == LAST_W) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_buffer.sv
// Scoreboard bench for capture_buffer: a sample-history model predicts each frozen window, a negedge monitor checks every pop.
module tb_capture_buffer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int PRE   = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             arm = 1'b0;
    logic             trig = 1'b0;
    logic             rd_ready = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic [3:0]       div = 4'd0;
    logic             rd_valid;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rd_data;

    int tests = 0;
    int fails = 0;

    typedef enum {M_IDLE, M_COLLECT, M_FINISH, M_READOUT} mphase_t;
    mphase_t          mPhase = M_IDLE;
    bit               mArmQ = 1'b0;
    logic [WIDTH-1:0] hist[$];
    logic [WIDTH-1:0] expQ[$];
    int               histCount = 0;
    int               postLeft = 0;
    int               readsLeft = 0;
    int               presc = 0;

    capture_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PRE(PRE)) dut (
        .clk(clk),
        .rst(rst),
        .arm(arm),
        .in_data(in_data),
        .trig(trig),
`ifdef CAPTURE_DECIM_EN
        .div(div),
`endif
        .rd_ready(rd_ready),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // The window is simply the last DEPTH samples taken; the monitor expects them oldest first.
    task automatic freezeWindow();
        check("window_size", hist.size(), DEPTH);
        foreach (hist[i]) expQ.push_back(hist[i]);
        mPhase    = M_READOUT;
        readsLeft = DEPTH;
    endtask

    task automatic takeSample(input logic [WIDTH-1:0] d);
        hist.push_back(d);
        if (hist.size() > DEPTH) void'(hist.pop_front());
        histCount++;
    endtask

    task automatic modelStep(input bit a, input bit t, input logic [WIDTH-1:0] d, input bit r);
        bit strobe;
        bit trigOk;
        case (mPhase)
            M_IDLE: begin
                if (a && !mArmQ) begin
                    mPhase = M_COLLECT;
                    hist.delete();
                    histCount = 0;
                    presc = 0;
                end
            end
            M_COLLECT, M_FINISH: begin
                if (!a) begin
                    mPhase = M_IDLE;
                end else begin
                    strobe = (presc == int'(div));
                    presc  = strobe ? 0 : presc + 1;
                    if (strobe) begin
                        if (mPhase == M_COLLECT) begin
                            trigOk = t && (histCount >= PRE);
                            takeSample(d);
                            if (trigOk) begin
                                postLeft = DEPTH - PRE - 1;
                                if (postLeft == 0) freezeWindow();
                                else mPhase = M_FINISH;
                            end
                        end else begin
                            takeSample(d);
                            postLeft--;
                            if (postLeft == 0) freezeWindow();
                        end
                    end
                end
            end
            M_READOUT: begin
                if (r) begin
                    readsLeft--;
                    if (readsLeft == 0) mPhase = M_IDLE;
                end
            end
            default: mPhase = M_IDLE;
        endcase
        mArmQ = a;
    endtask

    task automatic checkOutput();
        check("busy", busy, (mPhase == M_COLLECT || mPhase == M_FINISH));
        check("done", done, (mPhase == M_READOUT));
        check("rd_valid", rd_valid, (mPhase == M_READOUT));
        if (!rd_valid) check("rd_data_idle", rd_data, 0);
    endtask

    task automatic applyStimulus(input bit a, input bit t, input logic [WIDTH-1:0] d, input bit r);
        arm      = a;
        trig     = t;
        in_data  = d;
        rd_ready = r;
        modelStep(a, t, d, r);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic resetDut();
        rst = 1'b1;
        #1;
        expQ.delete();
        mPhase = M_IDLE;
        mArmQ  = 1'b0;
        arm    = 1'b0;
        checkOutput();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // readyMode: 0 always ready, 1 one cycle in three, 2 random, 3 never.
    task automatic runCapture(input int trigA, input int trigB, input int abortAt,
                              input int readyMode, input bit holdTrig, input bit randData,
                              input int maxCycles);
        bit r;
        bit finished = 1'b0;
        logic [WIDTH-1:0] d;
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        for (int k = 0; k < maxCycles; k++) begin
            case (readyMode)
                0:       r = 1'b1;
                1:       r = (k % 3 == 0);
                2:       r = 1'($urandom_range(0, 1));
                default: r = 1'b0;
            endcase
            d = randData ? WIDTH'($urandom) : WIDTH'(k);
            applyStimulus((abortAt < 0) || (k < abortAt),
                          holdTrig || (k == trigA) || (k == trigB), d, r);
            if (mPhase == M_IDLE) begin
                finished = 1'b1;
                break;
            end
        end
        if (readyMode != 3) begin
            check("capture_completed", finished, 1);
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
            check("window_fully_read", expQ.size(), 0);
        end
    endtask

    bit               prevStall = 1'b0;
    logic [WIDTH-1:0] prevData = '0;
    logic [WIDTH-1:0] expWord;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prevStall = 1'b0;
            end else begin
                if (prevStall) begin
                    check("stall_valid", rd_valid, 1);
                    check("stall_data", rd_data, prevData);
                end
                if (rd_valid && rd_ready) begin
                    if (expQ.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL extra_pop: got word %0h, expected no valid word", rd_data);
                    end else begin
                        expWord = expQ.pop_front();
                        check("rd_data", rd_data, expWord);
                    end
                end
                prevStall = rd_valid && !rd_ready;
                prevData  = rd_data;
            end
        end
    end

    initial begin
        // Reset held: outputs must stay quiet whatever arm does.
        for (int i = 0; i < 4; i++) begin
            arm = i[0];
            @(posedge clk);
            #1;
            checkOutput();
            check("reset_rd_data", rd_data, 0);
        end
        arm = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] basic capture, trigger on sample 20");
        runCapture(20, -1, -1, 0, 1'b0, 1'b0, 200);

        $display("[TB] early trigger ignored, trigger on sample 10");
        runCapture(3, 10, -1, 0, 1'b0, 1'b0, 200);

        $display("[TB] abort three cycles after trigger, then re-arm");
        runCapture(20, -1, 23, 0, 1'b0, 1'b0, 200);
        runCapture(15, -1, -1, 0, 1'b0, 1'b1, 200);

        $display("[TB] slow reader, one accept every three cycles");
        runCapture(20, -1, -1, 1, 1'b0, 1'b0, 300);

        $display("[TB] trigger held from the start");
        runCapture(-1, -1, -1, 0, 1'b1, 1'b1, 200);

        $display("[TB] reset while a frozen window is stalled");
        runCapture(10, -1, -1, 3, 1'b0, 1'b1, 25);
        resetDut();
        runCapture(12, -1, -1, 0, 1'b0, 1'b1, 200);

        $display("[TB] randomized captures");
        for (int n = 0; n < 8; n++) begin
            runCapture($urandom_range(0, 30), $urandom_range(8, 30),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 40)) : -1,
                       2, 1'b0, 1'b1, 300);
        end

`ifdef CAPTURE_DECIM_EN
        $display("[TB] decimated by two, trigger held");
        div = 4'd1;
        runCapture(-1, -1, -1, 0, 1'b1, 1'b0, 200);
        div = 4'd0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
